// File: rtl/mem_responder_if.sv
// Request/response bundle between the multicycle MIPS controller (master)
// and the memory responder (slave).
interface mem_responder_if;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] MemData;
    logic        MemValid;
    logic        AddrError;

    modport master (
        output Address, WriteData, MemWrite, MemRead,
        input  MemData, MemValid, AddrError
    );

    modport slave (
        input  Address, WriteData, MemWrite, MemRead,
        output MemData, MemValid, AddrError
    );
endinterface

// File: rtl/mem_responder.sv
// Word-organised RAM answering one read or write per cycle; read data returns
// through a fixed READ_LATENCY-deep pipeline with a valid strobe.
module mem_responder #(
    parameter int DEPTH_LOG2   = 8,
    parameter int READ_LATENCY = 2
) (
    input  logic            Clk,
    input  logic            Reset,
    mem_responder_if.slave  bus
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef struct packed {
        logic        valid;
        logic        err;
        logic [31:0] data;
    } slot_t;

    logic [31:0]           ram_q [DEPTH];
    slot_t                 pipe_q [READ_LATENCY];
    slot_t                 pipe_d [READ_LATENCY];
    logic                  wr_err_q, wr_err_d;

    logic [DEPTH_LOG2-1:0] word_idx;
    logic                  misaligned;
    logic                  ram_we;
    slot_t                 rd_slot;
    logic                  unused_addr_bits;

    // Upper address bits alias onto the same words.
    assign word_idx         = bus.Address[DEPTH_LOG2+1:2];
    assign misaligned       = bus.Address[1:0] != 2'b00;
    assign unused_addr_bits = ^bus.Address[31:DEPTH_LOG2+2];
    assign ram_we           = bus.MemWrite && !misaligned;

    // A stage keeps its data when a bubble passes so the last stage can hold
    // the previously delivered word on MemData.
    function automatic slot_t advance(slot_t in_s, slot_t cur);
        slot_t nxt;
        nxt = in_s;
        if (!in_s.valid) nxt.data = cur.data;
        return nxt;
    endfunction

    always_comb begin
        rd_slot       = '0;
        rd_slot.valid = bus.MemRead && !misaligned;
        rd_slot.err   = bus.MemRead && misaligned;
        // Sampled before this edge's write lands, so read-with-write sees old data.
        rd_slot.data  = ram_q[word_idx];

        pipe_d[0] = advance(rd_slot, pipe_q[0]);
        for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_d[i] = advance(pipe_q[i-1], pipe_q[i]);
        end

        wr_err_d = bus.MemWrite && misaligned;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pipe_q   <= '{default: '0};
            wr_err_q <= 1'b0;
        end else begin
            pipe_q   <= pipe_d;
            wr_err_q <= wr_err_d;
        end
    end

    // NOTE: the RAM array is deliberately left out of reset; Reset only
    // flushes the response pipeline and the contents must survive it.
    always_ff @(posedge Clk) begin
        if (ram_we) ram_q[word_idx] <= bus.WriteData;
    end

    assign bus.MemData   = pipe_q[READ_LATENCY-1].data;
    assign bus.MemValid  = pipe_q[READ_LATENCY-1].valid;
    assign bus.AddrError = pipe_q[READ_LATENCY-1].err || wr_err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Drives identical traffic into responders with read latency 1, 2 and 4 and
// compares every cycle against a word-array model with per-edge read records.
module tb_mem_responder;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_responder_if bus_l1 ();
    mem_responder_if bus_l2 ();
    mem_responder_if bus_l4 ();

    mem_responder #(.DEPTH_LOG2(8), .READ_LATENCY(1)) dut_l1 (.Clk(clk), .Reset(reset), .bus(bus_l1));
    mem_responder #(.DEPTH_LOG2(8), .READ_LATENCY(2)) dut_l2 (.Clk(clk), .Reset(reset), .bus(bus_l2));
    mem_responder #(.DEPTH_LOG2(8), .READ_LATENCY(4)) dut_l4 (.Clk(clk), .Reset(reset), .bus(bus_l4));

    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } rd_rec_t;

    rd_rec_t     rd_at [int];      // reads keyed by the edge that accepted them
    logic [31:0] mdl_mem [256];
    logic [31:0] last_data [3];
    int          edge_n;
    int          n_checks;
    int          n_fail;

    function automatic int lat_of(int k);
        case (k)
            0:       return 1;
            1:       return 2;
            default: return 4;
        endcase
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %h, expected %h", tag, edge_n, got, exp);
        end
    endtask

    task automatic drive(logic rd, logic wr, logic [31:0] addr, logic [31:0] wd);
        bus_l1.MemRead = rd; bus_l1.MemWrite = wr; bus_l1.Address = addr; bus_l1.WriteData = wd;
        bus_l2.MemRead = rd; bus_l2.MemWrite = wr; bus_l2.Address = addr; bus_l2.WriteData = wd;
        bus_l4.MemRead = rd; bus_l4.MemWrite = wr; bus_l4.Address = addr; bus_l4.WriteData = wd;
    endtask

    task automatic sample(int k, output logic v, output logic e, output logic [31:0] d);
        case (k)
            0:       begin v = bus_l1.MemValid; e = bus_l1.AddrError; d = bus_l1.MemData; end
            1:       begin v = bus_l2.MemValid; e = bus_l2.AddrError; d = bus_l2.MemData; end
            default: begin v = bus_l4.MemValid; e = bus_l4.AddrError; d = bus_l4.MemData; end
        endcase
    endtask

    task automatic check_outputs(logic wr_err);
        logic v, e;
        logic [31:0] d;
        for (int k = 0; k < 3; k++) begin
            int   src;
            logic exp_v, exp_e;
            src   = edge_n - lat_of(k) + 1;
            exp_v = 1'b0;
            exp_e = wr_err;
            if (rd_at.exists(src)) begin
                if (rd_at[src].err) exp_e = 1'b1;
                else begin
                    exp_v        = 1'b1;
                    last_data[k] = rd_at[src].data;
                end
            end
            sample(k, v, e, d);
            check($sformatf("L%0d MemValid", lat_of(k)),  32'(v), 32'(exp_v));
            check($sformatf("L%0d AddrError", lat_of(k)), 32'(e), 32'(exp_e));
            check($sformatf("L%0d MemData", lat_of(k)),   d,      last_data[k]);
        end
    endtask

    // One request cycle: drive at negedge, update the model at the edge, check 1 ns later.
    task automatic step(logic rd, logic wr, logic [31:0] addr, logic [31:0] wd);
        int   idx;
        logic mis;
        @(negedge clk);
        drive(rd, wr, addr, wd);
        @(posedge clk);
        edge_n++;
        idx = int'((addr % 32'd1024) / 32'd4);
        mis = (addr % 32'd4) != 0;
        if (rd) rd_at[edge_n] = '{err: mis, data: mis ? 32'h0 : mdl_mem[idx]};
        if (wr && !mis) mdl_mem[idx] = wd;
        #1;
        check_outputs(wr && mis);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic pulse_reset();
        logic v, e;
        logic [31:0] d;
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        reset = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            sample(k, v, e, d);
            check($sformatf("L%0d reset MemValid", lat_of(k)),  32'(v), 32'h0);
            check($sformatf("L%0d reset AddrError", lat_of(k)), 32'(e), 32'h0);
            check($sformatf("L%0d reset MemData", lat_of(k)),   d,      32'h0);
            last_data[k] = 32'h0;
        end
        rd_at.delete();
        @(posedge clk);
        edge_n++;
        #2 reset = 1'b0;
    endtask

    initial begin
        logic [31:0] addr;
        n_checks = 0;
        n_fail   = 0;
        edge_n   = 0;
        reset    = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        for (int k = 0; k < 3; k++) last_data[k] = 32'h0;

        pulse_reset();

        // Give every word a known value so the model never meets undefined RAM.
        for (int i = 0; i < 256; i++) step(1'b0, 1'b1, 32'(i * 4), $urandom);

        // Write then read after the configured latency.
        step(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
        step(1'b1, 1'b0, 32'h10, 32'h0);
        idle(5);

        // Back-to-back reads return back-to-back, in order.
        step(1'b0, 1'b1, 32'h10, 32'h11111111);
        step(1'b0, 1'b1, 32'h14, 32'h22222222);
        step(1'b1, 1'b0, 32'h10, 32'h0);
        step(1'b1, 1'b0, 32'h14, 32'h0);
        idle(5);

        // Simultaneous read and write return the old word.
        step(1'b0, 1'b1, 32'h20, 32'hA5A5A5A5);
        step(1'b1, 1'b1, 32'h20, 32'h5A5A5A5A);
        idle(1);
        step(1'b1, 1'b0, 32'h20, 32'h0);
        idle(5);

        // Misaligned write and read, plus both misaligned in one cycle.
        step(1'b0, 1'b1, 32'h11, 32'h12345678);
        step(1'b1, 1'b0, 32'h10, 32'h0);
        idle(5);
        step(1'b1, 1'b0, 32'h13, 32'h0);
        idle(5);
        step(1'b1, 1'b1, 32'h13, 32'h87654321);
        idle(5);

        // Reset discards an in-flight read but leaves the RAM intact.
        step(1'b1, 1'b0, 32'h10, 32'h0);
        pulse_reset();
        idle(5);
        step(1'b1, 1'b0, 32'h10, 32'h0);
        idle(5);

        // Address wrap-around modulo 1 KiB.
        step(1'b0, 1'b1, 32'h400, 32'hCAFEF00D);
        step(1'b1, 1'b0, 32'h000, 32'h0);
        idle(5);

        // Random traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
            if ($urandom_range(0, 1) != 0) addr = addr % 32'd128;
            if ($urandom_range(0, 79) == 0) pulse_reset();
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0), addr, $urandom);
        end
        idle(6);

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
